// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: pulses tick once every BAUD_DIV clocks.
// While clr is high the counter is held at 0, so the first tick after
// clr drops arrives exactly BAUD_DIV clocks later.
module uart_rx_tick #(
    parameter int unsigned BAUD_DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at BAUD_DIV-1, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampled 8N1 frames with a
// valid/ack holding register plus framing and overrun flags.
// Optional even-parity check: define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 651,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    rx_state_t            state_q, state_d;
    logic [3:0]           samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 commit_q, commit_d;
    logic                 pend_ferr_q, pend_ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 pend_perr_q, pend_perr_d;
    logic                 perr_q, perr_d;
`endif

    logic tick;
    logic tick_clr;

    assign tick_clr = (state_q == IDLE);

    uart_rx_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Synchronizer chain and previous-value flop for falling-edge detect.
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Frame FSM: start validation, data shift, optional parity, stop sample.
    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        commit_d    = 1'b0;
        pend_ferr_d = pend_ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
        pend_perr_d = pend_perr_q;
`endif
        case (state_q)
            IDLE: begin
                samp_d = '0;
                bit_d  = '0;
                if (prev_q && !sync2_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_q == 4'(MID_SAMPLE - 1)) begin
                        samp_d  = '0;
                        state_d = sync2_q ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'(OVERSAMPLE - 1)) begin
                        shift_d = (shift_q >> 1)
                                | (DATA_BITS'(sync2_q) << (DATA_BITS - 1));
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'(OVERSAMPLE - 1)) begin
                        par_d   = sync2_q;
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'(OVERSAMPLE - 1)) begin
                        pend_ferr_d = !sync2_q;
`ifdef UART_RX_PARITY_EN
                        pend_perr_d = par_q ^ (^shift_q);
`endif
                        commit_d    = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register: commit the frame or flag overrun; ack clears.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
`endif
        if (commit_q) begin
            if (!rx_valid_q || rd_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                ferr_d     = pend_ferr_q;
                ovr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_d     = pend_perr_q;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            ferr_d     = 1'b0;
            ovr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d     = 1'b0;
`endif
        end
    end

    // All receiver state; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            pend_ferr_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
            pend_perr_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            pend_ferr_q <= pend_ferr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
            pend_perr_q <= pend_perr_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = ferr_q;
    assign overrun_err = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at BAUD_DIV=4 (64 clocks per bit).
// Frames are bit-banged on rxd at negedges; a register-level model of the
// holding register predicts rx_data / rx_valid / error flags.
module tb_uart_rx;

    localparam int unsigned BAUD_DIV = 4;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS = PAR_EN ? 11 : 10;
    // Negedge index (frame start = 0) at which the commit cycle is open:
    // 3 clocks start-detect lag + stop sample at tick 8+16*(NBITS-1).
    localparam int COMMIT_IDX = 4 * (8 + 16 * (NBITS - 1)) + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overrun_err, parity_err;

    always #5 clk = ~clk;

    uart_rx #(
        .BAUD_DIV  (BAUD_DIV),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .rd_ack      (rd_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    int vecs = 0;
    int errs = 0;

    bit       m_valid, m_ferr, m_ovr, m_perr;
    bit [7:0] m_data;

    logic [11:0] obs;
    assign obs = {rx_valid, rx_data, framing_err, overrun_err, parity_err};

    function automatic logic [11:0] expv();
        return {m_valid, m_data, m_ferr, m_ovr, m_perr};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic model_frame(input bit [7:0] d, input bit stop, input bit par, input bit acked);
        bit pe;
        pe = PAR_EN && (par != ^d);
        if (!m_valid || acked) begin
            m_valid = 1; m_data = d; m_ferr = !stop; m_perr = pe; m_ovr = 0;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
        end
    endtask

    task automatic line_idle(input logic lvl, input int n);
        repeat (n) begin
            @(negedge clk);
            rxd = lvl;
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        model_ack();
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // Drive one frame; ack_idx>=0 pulses rd_ack at that negedge,
    // stop_at>=0 truncates the frame. rise_idx reports the rx_valid rise.
    task automatic send_frame(input bit [7:0] d, input bit stop, input bit par,
                              input int ack_idx, input int stop_at, output int rise_idx);
        logic [10:0] fb;
        logic lastv;
        int   n;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
        if (PAR_EN) fb[9] = par;
        fb[NBITS - 1] = stop;
        n = (stop_at >= 0) ? stop_at : NBITS * BIT_CLKS;
        rise_idx = -1;
        lastv = rx_valid;
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            if (rise_idx < 0 && lastv === 1'b0 && rx_valid === 1'b1) rise_idx = idx;
            lastv = rx_valid;
            rxd = fb[idx / BIT_CLKS];
            rd_ack = (idx == ack_idx);
        end
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        if (obs !== expv()) begin errs++; $display("FAIL reset: got %h expected %h", obs, expv()); end
        vecs++;
        reset = 1'b1;
        line_idle(1'b1, 10);
    endtask

    task automatic test_basic();
        bit [7:0] d;
        int r;
        d = 8'hA5;
        line_idle(1'b1, 8);
        send_frame(d, 1'b1, ^d, -1, -1, r);
        model_frame(d, 1'b1, ^d, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL basic_a5: got %h expected %h", obs, expv()); end
        vecs++;
        if (r !== COMMIT_IDX + 1) begin errs++; $display("FAIL basic_latency: got %0d expected %0d", r, COMMIT_IDX + 1); end
        vecs++;
        pulse_ack();
        if (obs !== expv()) begin errs++; $display("FAIL basic_ack: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
        if (obs !== expv()) begin errs++; $display("FAIL ack_when_empty: got %h expected %h", obs, expv()); end
        vecs++;
    endtask

    task automatic test_false_start();
        bit [7:0] d;
        int r;
        line_idle(1'b1, 8);
        line_idle(1'b0, 3 * BAUD_DIV);
        line_idle(1'b1, 12 * BIT_CLKS);
        if (obs !== expv()) begin errs++; $display("FAIL false_start: got %h expected %h", obs, expv()); end
        vecs++;
        d = 8'h3C;
        send_frame(d, 1'b1, ^d, -1, -1, r);
        model_frame(d, 1'b1, ^d, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL after_false_start: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
    endtask

    task automatic test_framing();
        bit [7:0] d;
        int r;
        d = 8'h55;
        line_idle(1'b1, 8);
        send_frame(d, 1'b0, ^d, -1, -1, r);
        model_frame(d, 1'b0, ^d, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL framing: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
        line_idle(1'b0, NBITS * BIT_CLKS + 64);
        if (obs !== expv()) begin errs++; $display("FAIL break_ignored: got %h expected %h", obs, expv()); end
        vecs++;
        line_idle(1'b1, 16);
        d = 8'h5A;
        send_frame(d, 1'b1, ^d, -1, -1, r);
        model_frame(d, 1'b1, ^d, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL rearm: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
    endtask

    task automatic test_overrun();
        bit [7:0] a, b;
        int r;
        a = 8'h11; b = 8'h22;
        line_idle(1'b1, 8);
        send_frame(a, 1'b1, ^a, -1, -1, r);
        model_frame(a, 1'b1, ^a, 1'b0);
        line_idle(1'b1, 8);
        send_frame(b, 1'b1, ^b, -1, -1, r);
        model_frame(b, 1'b1, ^b, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL overrun: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
        if (obs !== expv()) begin errs++; $display("FAIL overrun_clear: got %h expected %h", obs, expv()); end
        vecs++;
    endtask

    task automatic test_ack_commit();
        bit [7:0] a, b;
        int r;
        a = 8'h11; b = 8'h22;
        line_idle(1'b1, 8);
        send_frame(a, 1'b1, ^a, -1, -1, r);
        model_frame(a, 1'b1, ^a, 1'b0);
        line_idle(1'b1, 8);
        send_frame(b, 1'b1, ^b, COMMIT_IDX, -1, r);
        model_frame(b, 1'b1, ^b, 1'b1);
        if (obs !== expv()) begin errs++; $display("FAIL ack_at_commit: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
    endtask

    task automatic test_reset_abort();
        bit [7:0] d;
        int r;
        d = 8'hDB;
        line_idle(1'b1, 8);
        // Cut the frame in the middle of data bit 4.
        send_frame(d, 1'b1, ^d, -1, 5 * BIT_CLKS + 32, r);
        reset = 1'b0;
        rxd = 1'b1;
        model_reset();
        #1;
        if (obs !== expv()) begin errs++; $display("FAIL async_reset: got %h expected %h", obs, expv()); end
        vecs++;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        line_idle(1'b1, NBITS * BIT_CLKS);
        if (obs !== expv()) begin errs++; $display("FAIL abort_no_commit: got %h expected %h", obs, expv()); end
        vecs++;
        d = 8'hF0;
        send_frame(d, 1'b1, ^d, -1, -1, r);
        model_frame(d, 1'b1, ^d, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL after_abort: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
    endtask

    task automatic test_parity();
        bit [7:0] d;
        int r;
        d = 8'h01;
        line_idle(1'b1, 8);
        send_frame(d, 1'b1, 1'b0, -1, -1, r);
        model_frame(d, 1'b1, 1'b0, 1'b0);
        if (obs !== expv()) begin errs++; $display("FAIL parity_bad: got %h expected %h", obs, expv()); end
        vecs++;
        pulse_ack();
    endtask

    task automatic test_random();
        bit [7:0] d;
        bit stop, par;
        int mode, r;
        for (int k = 0; k < 10; k++) begin
            line_idle(1'b1, $urandom_range(60, 8));
            d = 8'($urandom);
            stop = ($urandom_range(3, 0) != 0);
            par = (^d) ^ ($urandom_range(3, 0) == 0);
            mode = $urandom_range(2, 0);
            send_frame(d, stop, par, (mode == 1) ? COMMIT_IDX : -1, -1, r);
            model_frame(d, stop, par, mode == 1);
            if (obs !== expv()) begin errs++; $display("FAIL rand_frame%0d: got %h expected %h", k, obs, expv()); end
            vecs++;
            if (mode == 2) begin
                pulse_ack();
                if (obs !== expv()) begin errs++; $display("FAIL rand_ack%0d: got %h expected %h", k, obs, expv()); end
                vecs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_overrun();
        test_ack_commit();
        test_reset_abort();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
